alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
Shares one combinational `alu` instance between NREQ issue requesters (reservation-station slots) using round-robin arbitration. The winner's op and operands pass through the ALU the cycle they are granted. The result, its destination tag and the requester index are captured in a single output register with valid/ready backpressure toward the result/CDB port. A flush input drops speculative work in flight.

Parameters:
NREQ, 2, number of requesters (2..4)
TAG_WIDTH, 6, destination rename tag width
IDX_WIDTH, 1, width of requester index (clog2(NREQ), minimum 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester valid
req_op  in  NREQ*`ALU_OP_WIDTH  per-requester ALU op, requester i at slice i
req_src1  in  NREQ*`XPR_LEN  per-requester operand 1
req_src2  in  NREQ*`XPR_LEN  per-requester operand 2
req_tag  in  NREQ*TAG_WIDTH  per-requester destination tag
req_ready  out  NREQ  one-hot grant; the request is consumed this cycle
flush  in  1  kill the output register and suppress grants this cycle
out_valid  out  1  result register valid
out_data  out  `XPR_LEN  ALU result
out_tag  out  TAG_WIDTH  destination tag of the result
out_src  out  IDX_WIDTH  index of the requester that produced the result
out_ready  in  1  consumer accepts the result this cycle
busy_cnt  out  16  saturating count of cycles with a request pending but not granted (stall statistic)

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high. While reset is high: out_valid=0, out_data=0, out_tag=0, out_src=0, rr pointer=0, busy_cnt=0. req_ready is forced to 0.
- Accept condition: accept = !flush && (!out_valid || out_ready).
- Grant:
  - If accept and any req_valid is set, exactly one req_ready bit is asserted. It goes to the first valid requester searching from rr pointer p upward, modulo NREQ.
  - Otherwise req_ready=0.
  - req_ready is combinational from req_valid, p, out_valid, out_ready and flush.
- Datapath: the granted slice drives the `alu` op/in1/in2 in the same cycle. The ALU result is unmodified; op encodings are those of alu_ops.vh.
- Output register update, applied on the clock edge in priority order:
  - flush: out_valid<=0. Data, tag and src registers are don't-care.
  - grant: out_valid<=1; out_data/out_tag/out_src are loaded.
  - out_ready && out_valid (no grant): out_valid<=0.
  - otherwise: hold.
- Latency: grant at cycle N gives out_valid=1 at cycle N+1. Throughput is 1 result/cycle while out_ready stays high.
- Backpressure: out_valid && !out_ready holds all output fields stable and grants nothing.
- Round robin: on grant to index g, p<=(g+1) mod NREQ. Without a grant, p holds. Flush does not move p.
- Requester contract: while req_valid is high and req_ready is low, the requester holds op, src1, src2 and tag stable. The block tolerates requests dropped without a grant.
- busy_cnt: increments when |req_valid && no grant && !flush. It saturates at 16'hFFFF and clears only on reset.
- Simultaneous events:
  - Drain and refill in the same cycle (out_valid && out_ready && grant) loads the new result with no bubble.
  - flush together with out_ready produces no grant, and out_valid=0 next cycle.
- Reset mid-operation: any held result is discarded. The first grant after reset goes to requester 0 if it is valid.

Decomposition:
- ALU op codes, `ALU_OP_WIDTH` and `XPR_LEN` come from the existing alu_ops.vh and rv32_opcodes.vh. Add no new package contents except the NREQ/IDX_WIDTH defaults, if shared with the issue logic.
- Sub-modules:
  - Instantiate the existing `alu` unmodified.
  - Factor the priority search into one sub-module, `rr_arbiter` (inputs req, ptr; output one-hot grant and encoded index), so the issue queue can reuse it.

Test Plan:
1. Reset: hold reset 2 cycles with all req_valid=1 -> req_ready=0, out_valid=0, busy_cnt=0. After release, first grant is req_ready=2'b01.
2. Single op: req0 op=ALU_OP_ADD, src1=5, src2=7, tag=3, out_ready=1 -> next cycle out_valid=1, out_data=12, out_tag=3, out_src=0.
3. Round robin: both requesters valid for 4 cycles, out_ready=1 -> grants 01,10,01,10. Results are SUB(10,3)=7 from req0 and SLTU(1,2)=1 from req1, tagged correctly.
4. Backpressure: result held with out_ready=0 for 3 cycles while req1 is valid -> req_ready=0, out_* stable, busy_cnt +3. Then out_ready=1 -> req1 granted the same cycle, and its result appears with no bubble.
5. Flush: out_valid=1 and req0 valid, assert flush -> no grant, out_valid=0 next cycle, rr pointer unchanged (the next grant goes to the same index it would have).
6. Saturation and SRA: force 65540 stall cycles -> busy_cnt=16'hFFFF. Separately, ALU_OP_SRA src1=32'h80000000, src2=4 -> out_data=32'hF8000000.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// rtl/alu_share_arb_pkg.sv - shared widths, ALU op codes and arbiter defaults
// Op encodings mirror the core's ALU op table so results stay bit-compatible.
package alu_share_arb_pkg;

  localparam int XPR_LEN      = 32;
  localparam int ALU_OP_WIDTH = 4;
  localparam int SHAMT_WIDTH  = 5;

  typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD  = 4'd0;
  localparam alu_op_t ALU_OP_SLL  = 4'd1;
  localparam alu_op_t ALU_OP_XOR  = 4'd4;
  localparam alu_op_t ALU_OP_SRL  = 4'd5;
  localparam alu_op_t ALU_OP_OR   = 4'd6;
  localparam alu_op_t ALU_OP_AND  = 4'd7;
  localparam alu_op_t ALU_OP_SEQ  = 4'd8;
  localparam alu_op_t ALU_OP_SNE  = 4'd9;
  localparam alu_op_t ALU_OP_SUB  = 4'd10;
  localparam alu_op_t ALU_OP_SRA  = 4'd11;
  localparam alu_op_t ALU_OP_SLT  = 4'd12;
  localparam alu_op_t ALU_OP_SGE  = 4'd13;
  localparam alu_op_t ALU_OP_SLTU = 4'd14;
  localparam alu_op_t ALU_OP_SGEU = 4'd15;

  localparam int NREQ_DEFAULT      = 2;
  localparam int TAG_WIDTH_DEFAULT = 6;
  localparam int IDX_WIDTH_DEFAULT = 1;

endpackage

// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - requester and result-port bundle for the shared ALU
// master = issue side / result consumer, slave = the arbiter block.
interface alu_share_arb_if #(
  parameter int NREQ      = 2,
  parameter int TAG_WIDTH = 6,
  parameter int IDX_WIDTH = 1
);
  import alu_share_arb_pkg::*;

  logic [NREQ-1:0]              req_valid;
  logic [NREQ*ALU_OP_WIDTH-1:0] req_op;
  logic [NREQ*XPR_LEN-1:0]      req_src1;
  logic [NREQ*XPR_LEN-1:0]      req_src2;
  logic [NREQ*TAG_WIDTH-1:0]    req_tag;
  logic [NREQ-1:0]              req_ready;

  logic                         out_valid;
  logic [XPR_LEN-1:0]           out_data;
  logic [TAG_WIDTH-1:0]         out_tag;
  logic [IDX_WIDTH-1:0]         out_src;
  logic                         out_ready;

  modport master (
    output req_valid, req_op, req_src1, req_src2, req_tag, out_ready,
    input  req_ready, out_valid, out_data, out_tag, out_src
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, req_tag, out_ready,
    output req_ready, out_valid, out_data, out_tag, out_src
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU
// Shifts use only the low SHAMT_WIDTH bits of in2.
module alu
  import alu_share_arb_pkg::*;
(
  input  alu_op_t            op,
  input  logic [XPR_LEN-1:0] in1,
  input  logic [XPR_LEN-1:0] in2,
  output logic [XPR_LEN-1:0] out
);

  logic [SHAMT_WIDTH-1:0] shamt;

  assign shamt = in2[SHAMT_WIDTH-1:0];

  always_comb begin
    out = '0;
    case (op)
      ALU_OP_ADD:  out = in1 + in2;
      ALU_OP_SLL:  out = in1 << shamt;
      ALU_OP_XOR:  out = in1 ^ in2;
      ALU_OP_OR:   out = in1 | in2;
      ALU_OP_AND:  out = in1 & in2;
      ALU_OP_SRL:  out = in1 >> shamt;
      ALU_OP_SEQ:  out = {{(XPR_LEN-1){1'b0}}, in1 == in2};
      ALU_OP_SNE:  out = {{(XPR_LEN-1){1'b0}}, in1 != in2};
      ALU_OP_SUB:  out = in1 - in2;
      ALU_OP_SRA:  out = $signed(in1) >>> shamt;
      ALU_OP_SLT:  out = {{(XPR_LEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      ALU_OP_SGE:  out = {{(XPR_LEN-1){1'b0}}, $signed(in1) >= $signed(in2)};
      ALU_OP_SLTU: out = {{(XPR_LEN-1){1'b0}}, in1 < in2};
      ALU_OP_SGEU: out = {{(XPR_LEN-1){1'b0}}, in1 >= in2};
      default:     out = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// rtl/alu_share_arb_rr_arbiter.sv - rr_arbiter: first set request at or above ptr, wrapping
// Kept standalone so the issue queue can reuse the same search.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one ALU among issue slots
// Winner computes in the grant cycle; result/tag/source land in one output register.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEFAULT,
  parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
  parameter int IDX_WIDTH = IDX_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  alu_share_arb_if.slave       bus,
  output logic [15:0]          busy_cnt
);

  logic                 out_valid_q, out_valid_d;
  logic [XPR_LEN-1:0]   out_data_q,  out_data_d;
  logic [TAG_WIDTH-1:0] out_tag_q,   out_tag_d;
  logic [IDX_WIDTH-1:0] out_src_q,   out_src_d;
  logic [IDX_WIDTH-1:0] ptr_q,       ptr_d;
  logic [15:0]          busy_q,      busy_d;

  logic                 accept;
  logic [NREQ-1:0]      arb_req;
  logic [NREQ-1:0]      arb_gnt;
  logic [IDX_WIDTH-1:0] arb_idx;
  logic                 grant;

  alu_op_t              sel_op;
  logic [XPR_LEN-1:0]   sel_src1;
  logic [XPR_LEN-1:0]   sel_src2;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic [XPR_LEN-1:0]   alu_out;

  // Masking the arbiter input keeps req_ready zero in reset, flush and stall.
  assign accept  = !flush && (!out_valid_q || bus.out_ready);
  assign arb_req = (accept && !reset) ? bus.req_valid : '0;
  assign grant   = |arb_gnt;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDX_WIDTH)
  ) u_rr_arbiter (
    .req (arb_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    sel_op   = '0;
    sel_src1 = '0;
    sel_src2 = '0;
    sel_tag  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_WIDTH'(i)) begin
        sel_op   = bus.req_op[i*ALU_OP_WIDTH +: ALU_OP_WIDTH];
        sel_src1 = bus.req_src1[i*XPR_LEN +: XPR_LEN];
        sel_src2 = bus.req_src2[i*XPR_LEN +: XPR_LEN];
        sel_tag  = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  alu u_alu (
    .op  (sel_op),
    .in1 (sel_src1),
    .in2 (sel_src2),
    .out (alu_out)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = alu_out;
      out_tag_d   = sel_tag;
      out_src_d   = arb_idx;
      ptr_d       = (arb_idx == IDX_WIDTH'(NREQ-1)) ? '0 : arb_idx + IDX_WIDTH'(1);
    end else if (bus.out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end

    if ((bus.req_valid != '0) && !grant && !flush && (busy_q != 16'hFFFF)) begin
      busy_d = busy_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = arb_gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_src   = out_src_q;
  assign busy_cnt      = busy_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb
// Reference model tracks the result register, rr pointer and stall counter from the rules.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int TW   = 6;
  localparam int IW   = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] busy_cnt;

  int total = 0;
  int bad   = 0;

  alu_share_arb_if #(.NREQ(NREQ), .TAG_WIDTH(TW), .IDX_WIDTH(IW)) bus ();

  alu_share_arb #(.NREQ(NREQ), .TAG_WIDTH(TW), .IDX_WIDTH(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  // reference state
  bit              m_valid;
  logic [31:0]     m_data;
  logic [TW-1:0]   m_tag;
  logic [IW-1:0]   m_src;
  int              m_ptr;
  int              m_busy;

  logic [NREQ-1:0] obs_gnt;
  logic [NREQ-1:0] exp_gnt;

  function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      ALU_OP_ADD:  return a + b;
      ALU_OP_SUB:  return a - b;
      ALU_OP_SLL:  return a << sh;
      ALU_OP_SRL:  return a >> sh;
      ALU_OP_SRA:  return 32'($signed(a) >>> sh);
      ALU_OP_XOR:  return a ^ b;
      ALU_OP_OR:   return a | b;
      ALU_OP_AND:  return a & b;
      ALU_OP_SEQ:  return (a == b) ? 32'd1 : 32'd0;
      ALU_OP_SNE:  return (a != b) ? 32'd1 : 32'd0;
      ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_OP_SGE:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_OP_SGEU: return (a >= b) ? 32'd1 : 32'd0;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic int model_pick();
    if (reset || flush || (m_valid && !bus.out_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (reset) begin
      m_valid = 0; m_data = '0; m_tag = '0; m_src = '0; m_ptr = 0; m_busy = 0;
      return;
    end
    if ((bus.req_valid != '0) && g < 0 && !flush && m_busy < 65535) m_busy++;
    if (flush) begin
      m_valid = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_data  = ref_alu(alu_op_t'(bus.req_op[g*4 +: 4]), bus.req_src1[g*32 +: 32], bus.req_src2[g*32 +: 32]);
      m_tag   = bus.req_tag[g*TW +: TW];
      m_src   = IW'(g);
      m_ptr   = (g + 1) % NREQ;
    end else if (bus.out_ready && m_valid) begin
      m_valid = 0;
    end
  endtask

  // One clock: sample the combinational grant mid-cycle, then advance the model at the edge.
  task automatic tick();
    int g;
    @(negedge clk);
    obs_gnt = bus.req_ready;
    g = model_pick();
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input alu_op_t op,
                         input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
    bus.req_valid[i]         = v;
    bus.req_op[i*4 +: 4]     = op;
    bus.req_src1[i*32 +: 32] = a;
    bus.req_src2[i*32 +: 32] = b;
    bus.req_tag[i*TW +: TW]  = t;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, ALU_OP_ADD, 32'd1, 32'd1, 6'd1);
    set_req(1, 1'b1, ALU_OP_ADD, 32'd2, 32'd2, 6'd2);
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (obs_gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", obs_gnt); end
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_tag !== '0 || bus.out_src !== '0) begin
      bad++; $display("FAIL reset_out got v=%b d=%h t=%h s=%h want all zero",
                      bus.out_valid, bus.out_data, bus.out_tag, bus.out_src);
    end
    total++;
    if (busy_cnt !== 16'd0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy_cnt); end
    reset = 1'b0;
    tick();
    total++;
    if (obs_gnt !== 2'b01) begin bad++; $display("FAIL first_grant got=%b want=01", obs_gnt); end
  endtask

  task automatic test_single();
    set_req(0, 1'b0, ALU_OP_ADD, 32'd0, 32'd0, 6'd0);
    set_req(1, 1'b0, ALU_OP_ADD, 32'd0, 32'd0, 6'd0);
    tick();
    set_req(0, 1'b1, ALU_OP_ADD, 32'd5, 32'd7, 6'd3);
    tick();
    total++;
    if (obs_gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b want=01", obs_gnt); end
    set_req(0, 1'b0, ALU_OP_ADD, 32'd0, 32'd0, 6'd0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd12 || bus.out_tag !== 6'd3 || bus.out_src !== 1'b0) begin
      bad++; $display("FAIL single_out got v=%b d=%0d t=%0d s=%0d want v=1 d=12 t=3 s=0",
                      bus.out_valid, bus.out_data, bus.out_tag, bus.out_src);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] want;
    do_reset();
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, ALU_OP_SUB,  32'd10, 32'd3, 6'd5);
    set_req(1, 1'b1, ALU_OP_SLTU, 32'd1,  32'd2, 6'd9);
    for (int c = 0; c < 4; c++) begin
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      total++;
      if (obs_gnt !== want) begin bad++; $display("FAIL rr_gnt[%0d] got=%b want=%b", c, obs_gnt, want); end
      total++;
      if (c % 2 == 0) begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd7 || bus.out_tag !== 6'd5 || bus.out_src !== 1'b0) begin
          bad++; $display("FAIL rr_out[%0d] got d=%0d t=%0d s=%0d want d=7 t=5 s=0", c, bus.out_data, bus.out_tag, bus.out_src);
        end
      end else begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1 || bus.out_tag !== 6'd9 || bus.out_src !== 1'b1) begin
          bad++; $display("FAIL rr_out[%0d] got d=%0d t=%0d s=%0d want d=1 t=9 s=1", c, bus.out_data, bus.out_tag, bus.out_src);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]   h_data;
    logic [TW-1:0] h_tag;
    logic [IW-1:0] h_src;
    int            busy0;
    h_data = m_data; h_tag = m_tag; h_src = m_src; busy0 = m_busy;
    bus.out_ready = 1'b0;
    set_req(0, 1'b0, ALU_OP_ADD, 32'd0, 32'd0, 6'd0);
    set_req(1, 1'b1, ALU_OP_XOR, 32'hF0, 32'h0F, 6'd7);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (obs_gnt !== 2'b00) begin bad++; $display("FAIL bp_gnt[%0d] got=%b want=00", c, obs_gnt); end
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== h_data || bus.out_tag !== h_tag || bus.out_src !== h_src) begin
        bad++; $display("FAIL bp_hold[%0d] got d=%h t=%h s=%h want d=%h t=%h s=%h",
                        c, bus.out_data, bus.out_tag, bus.out_src, h_data, h_tag, h_src);
      end
    end
    total++;
    if (busy_cnt !== 16'(busy0 + 3)) begin bad++; $display("FAIL bp_busy got=%0d want=%0d", busy_cnt, busy0 + 3); end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (obs_gnt !== 2'b10) begin bad++; $display("FAIL bp_release_gnt got=%b want=10", obs_gnt); end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFF || bus.out_tag !== 6'd7 || bus.out_src !== 1'b1) begin
      bad++; $display("FAIL bp_refill got v=%b d=%h t=%0d s=%0d want v=1 d=ff t=7 s=1",
                      bus.out_valid, bus.out_data, bus.out_tag, bus.out_src);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b1;
    flush = 1'b1;
    set_req(0, 1'b1, ALU_OP_AND, 32'hFF00, 32'h0FF0, 6'd11);
    set_req(1, 1'b0, ALU_OP_ADD, 32'd0, 32'd0, 6'd0);
    tick();
    total++;
    if (obs_gnt !== 2'b00) begin bad++; $display("FAIL flush_gnt got=%b want=00", obs_gnt); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", bus.out_valid); end
    flush = 1'b0;
    set_req(1, 1'b1, ALU_OP_OR, 32'h1, 32'h2, 6'd12);
    tick();
    total++;
    if (obs_gnt !== 2'b01) begin bad++; $display("FAIL flush_ptr_gnt got=%b want=01", obs_gnt); end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0F00 || bus.out_tag !== 6'd11) begin
      bad++; $display("FAIL flush_after got v=%b d=%h t=%0d want v=1 d=0f00 t=11", bus.out_valid, bus.out_data, bus.out_tag);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !exp_gnt[i]) begin
          if ($urandom_range(0, 7) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          set_req(i, 1'($urandom_range(0, 1)), alu_op_t'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40)),
                  ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40)),
                  TW'($urandom()));
        end
      end
      tick();
      total++;
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL rand_gnt[%0d] got=%b want=%b", c, obs_gnt, exp_gnt); end
      total++;
      if (bus.out_valid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d] got=%b want=%b", c, bus.out_valid, m_valid); end
      if (m_valid) begin
        total++;
        if (bus.out_data !== m_data || bus.out_tag !== m_tag || bus.out_src !== m_src) begin
          bad++; $display("FAIL rand_out[%0d] got d=%h t=%h s=%h want d=%h t=%h s=%h",
                          c, bus.out_data, bus.out_tag, bus.out_src, m_data, m_tag, m_src);
        end
      end
      total++;
      if (busy_cnt !== 16'(m_busy)) begin bad++; $display("FAIL rand_busy[%0d] got=%0d want=%0d", c, busy_cnt, m_busy); end
    end
    flush = 1'b0;
  endtask

  task automatic test_sra_saturation();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, ALU_OP_SRA, 32'h80000000, 32'd4, 6'd21);
    set_req(1, 1'b0, ALU_OP_ADD, 32'd0, 32'd0, 6'd0);
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hF8000000) begin
      bad++; $display("FAIL sra got v=%b d=%h want v=1 d=f8000000", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b0;
    set_req(0, 1'b0, ALU_OP_ADD, 32'd0, 32'd0, 6'd0);
    set_req(1, 1'b1, ALU_OP_ADD, 32'd1, 32'd1, 6'd22);
    for (int c = 0; c < 65540; c++) tick();
    total++;
    if (busy_cnt !== 16'hFFFF) begin bad++; $display("FAIL busy_sat got=%h want=ffff", busy_cnt); end
    total++;
    if (bus.out_data !== 32'hF8000000 || bus.out_tag !== 6'd21) begin
      bad++; $display("FAIL sat_hold got d=%h t=%0d want d=f8000000 t=21", bus.out_data, bus.out_tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.req_tag   = '0;
    bus.out_ready = 1'b0;
    m_valid = 0; m_data = '0; m_tag = '0; m_src = '0; m_ptr = 0; m_busy = 0;
    exp_gnt = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_random();
    test_sra_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
